// File: rtl/sec_a2b_sched.sv
// -----------------------------------------------------------------------------
// sec_a2b_sched -- issue scheduler for the pipelined masked A2B converter.
//
// Arbitrates N_REQ requesters round-robin and issues one arithmetic-share word
// per cycle to the converter whenever fresh randomness is present.  A credit
// counter keeps the number of words in flight plus words parked in the output
// FIFO at or below OUT_DEPTH, so a converter result always finds a free slot.
// Each word in flight carries its requester id in a tag pipe that mirrors the
// converter latency.  A halt/drain handshake lets a requester quiesce the
// converter before a key or PRNG reseed.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_vld/req_data      per-requester valid and masked word (slice i*MASKWIDTH)
//   req_rdy               one-hot grant, high only in the issue cycle
//   rnd_vld/rnd_rdy       randomness available / consumed this cycle
//   a2b_dvld/a2b_ena/a2b_a   issue strobe, enable and shares to the converter
//   a2b_ovld/a2b_z        converter result valid and Boolean shares
//   rsp_vld/rsp_rdy/rsp_data/rsp_id   output FIFO head and its requester id
//   halt_req/halt_ack     stop issuing and drain / drained and stopped
//   err                   sticky: a2b_ovld disagreed with the tag pipe
//
// Build option
//   SEC_A2B_SCHED_ZEROIZE_EN : a2b_a is 0 on idle cycles, popped FIFO entries
//   are cleared and rsp_data reads 0 while rsp_vld is low.
// -----------------------------------------------------------------------------
module sec_a2b_sched #(
    parameter int K_WIDTH   = 32,
    parameter int N_SHARES  = 4,
    parameter int MASKWIDTH = K_WIDTH * N_SHARES,
    parameter int N_REQ     = 4,
    parameter int A2B_LAT   = 10,
    parameter int OUT_DEPTH = 4,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    input  logic [N_REQ*MASKWIDTH-1:0] req_data,
    output logic [N_REQ-1:0]           req_rdy,
    input  logic                       rnd_vld,
    output logic                       rnd_rdy,
    output logic                       a2b_dvld,
    output logic                       a2b_ena,
    output logic [MASKWIDTH-1:0]       a2b_a,
    input  logic                       a2b_ovld,
    input  logic [MASKWIDTH-1:0]       a2b_z,
    output logic                       rsp_vld,
    input  logic                       rsp_rdy,
    output logic [MASKWIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]            rsp_id,
    input  logic                       halt_req,
    output logic                       halt_ack,
    output logic                       err
);
    localparam int CRED_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int MUTE_W = $clog2(A2B_LAT + 1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

    state_t                state_reg, state_next;
    logic [ID_W-1:0]       rr_ptr_reg;
    logic [CRED_W-1:0]     credit_reg;
    logic [CRED_W-1:0]     fifo_cnt_reg;
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic                  a2b_dvld_reg, a2b_ena_reg;
    logic [MASKWIDTH-1:0]  a2b_a_reg;
    logic [ID_W-1:0]       issue_id_reg;
    logic [MUTE_W-1:0]     mute_reg;
    logic                  err_reg;

    logic [A2B_LAT-1:0]    tag_vld_reg, tag_vld_in;
    logic [ID_W-1:0]       tag_id_reg [A2B_LAT];
    logic [ID_W-1:0]       tag_id_in  [A2B_LAT];

    logic [MASKWIDTH-1:0]  fifo_data_reg [OUT_DEPTH];
    logic [ID_W-1:0]       fifo_id_reg   [OUT_DEPTH];

    logic [MASKWIDTH-1:0]  req_word [N_REQ];
    logic                  grant_found;
    logic [ID_W-1:0]       grant_idx, grant_cand;
    logic                  issue, fifo_push, fifo_pop, inflight_any;

    genvar gi;

    // ---------------- round-robin grant ----------------
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_word[gi] = req_data[gi*MASKWIDTH +: MASKWIDTH];
            assign req_rdy[gi]  = issue && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Scan from the farthest candidate back to the pointer so the last hit,
    // i.e. the nearest set bit at or after the pointer, wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            grant_cand = ID_W'((int'(rr_ptr_reg) + k) % N_REQ);
            if (req_vld[grant_cand]) begin
                grant_found = 1'b1;
                grant_idx   = grant_cand;
            end
        end
    end

    assign issue   = !rst && (state_reg == ST_RUN) && rnd_vld &&
                     (credit_reg != '0) && grant_found;
    assign rnd_rdy = issue;

    // ---------------- issue stage ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a2b_dvld_reg <= 1'b0;
            a2b_ena_reg  <= 1'b0;
            a2b_a_reg    <= '0;
            issue_id_reg <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            a2b_dvld_reg <= issue;
            a2b_ena_reg  <= 1'b1;
            if (issue) begin
                a2b_a_reg    <= req_word[grant_idx];
                issue_id_reg <= grant_idx;
                rr_ptr_reg   <= ID_W'((int'(grant_idx) + 1) % N_REQ);
            end
`ifdef SEC_A2B_SCHED_ZEROIZE_EN
            else begin
                a2b_a_reg <= '0;
            end
`endif
        end
    end

    assign a2b_dvld = a2b_dvld_reg;
    assign a2b_ena  = a2b_ena_reg;
    assign a2b_a    = a2b_a_reg;

    // ---------------- tag pipe ----------------
    // Fed from the issue register, so the last stage lines up with a2b_ovld
    // exactly A2B_LAT cycles after a2b_dvld.
    generate
        for (gi = 0; gi < A2B_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_vld_in[gi] = a2b_dvld_reg;
                assign tag_id_in[gi]  = issue_id_reg;
            end else begin : g_body
                assign tag_vld_in[gi] = tag_vld_reg[gi-1];
                assign tag_id_in[gi]  = tag_id_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_reg <= '0;
            tag_id_reg  <= '{default: '0};
        end else begin
            tag_vld_reg <= tag_vld_in;
            tag_id_reg  <= tag_id_in;
        end
    end

    assign inflight_any = a2b_dvld_reg || (|tag_vld_reg);
    // Untagged results are dropped; only tagged ones occupy a FIFO slot.
    assign fifo_push    = a2b_ovld && tag_vld_reg[A2B_LAT-1];

    // ---------------- error monitor ----------------
    // A converter flushed by rst may still emit results for up to A2B_LAT
    // cycles; those are ignored rather than flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            mute_reg <= MUTE_W'(A2B_LAT);
            err_reg  <= 1'b0;
        end else begin
            if (mute_reg != '0)
                mute_reg <= mute_reg - 1'b1;
            if ((mute_reg == '0) && (tag_vld_reg[A2B_LAT-1] != a2b_ovld))
                err_reg <= 1'b1;
        end
    end

    assign err = err_reg;

    // ---------------- output FIFO ----------------
    assign rsp_vld  = (fifo_cnt_reg != '0);
    assign fifo_pop = rsp_vld && rsp_rdy;
    assign rsp_id   = fifo_id_reg[rd_ptr_reg];
`ifdef SEC_A2B_SCHED_ZEROIZE_EN
    assign rsp_data = rsp_vld ? fifo_data_reg[rd_ptr_reg] : '0;
`else
    assign rsp_data = fifo_data_reg[rd_ptr_reg];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_data_reg[i] <= '0;
                fifo_id_reg[i]   <= '0;
            end
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
            credit_reg   <= CRED_W'(OUT_DEPTH);
        end else begin
`ifdef SEC_A2B_SCHED_ZEROIZE_EN
            // Clear first so a same-slot write (full FIFO, push and pop) wins.
            if (fifo_pop)
                fifo_data_reg[rd_ptr_reg] <= '0;
`endif
            if (fifo_push) begin
                fifo_data_reg[wr_ptr_reg] <= a2b_z;
                fifo_id_reg[wr_ptr_reg]   <= tag_id_reg[A2B_LAT-1];
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (fifo_pop)
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            fifo_cnt_reg <= fifo_cnt_reg + CRED_W'(fifo_push) - CRED_W'(fifo_pop);
            // A credit leaves at issue and returns when its result is popped.
            credit_reg   <= credit_reg + CRED_W'(fifo_pop) - CRED_W'(issue);
        end
    end

    // ---------------- halt / drain FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= ST_RUN;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (halt_req)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!halt_req)
                    state_next = ST_RUN;
                else if (!inflight_any && (fifo_cnt_reg == '0))
                    state_next = ST_HALT;
            end
            ST_HALT: begin
                if (!halt_req)
                    state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign halt_ack = (state_reg == ST_HALT);

endmodule

// File: tb/tb_sec_a2b_sched.sv
`timescale 1ns/1ps
module tb_sec_a2b_sched;
    localparam int K_WIDTH   = 32;
    localparam int N_SHARES  = 4;
    localparam int MASKWIDTH = K_WIDTH * N_SHARES;
    localparam int N_REQ     = 4;
    localparam int A2B_LAT   = 10;
    localparam int OUT_DEPTH = 4;
    localparam int ID_W      = 2;
    localparam int S_RUN = 0, S_DRAIN = 1, S_HALT = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [N_REQ-1:0]           req_vld;
    logic [N_REQ*MASKWIDTH-1:0] req_data;
    logic [N_REQ-1:0]           req_rdy;
    logic                       rnd_vld, rnd_rdy;
    logic                       a2b_dvld, a2b_ena;
    logic [MASKWIDTH-1:0]       a2b_a;
    logic                       a2b_ovld;
    logic [MASKWIDTH-1:0]       a2b_z;
    logic                       rsp_vld, rsp_rdy;
    logic [MASKWIDTH-1:0]       rsp_data;
    logic [ID_W-1:0]            rsp_id;
    logic                       halt_req, halt_ack, err;

    always #5 clk = ~clk;

    sec_a2b_sched #(
        .K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES), .MASKWIDTH(MASKWIDTH),
        .N_REQ(N_REQ), .A2B_LAT(A2B_LAT), .OUT_DEPTH(OUT_DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
        .rnd_vld(rnd_vld), .rnd_rdy(rnd_rdy),
        .a2b_dvld(a2b_dvld), .a2b_ena(a2b_ena), .a2b_a(a2b_a),
        .a2b_ovld(a2b_ovld), .a2b_z(a2b_z),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .halt_req(halt_req), .halt_ack(halt_ack), .err(err)
    );

    // Expected results in issue order: requester id and the unmasked secret.
    typedef struct { int id; logic [K_WIDTH-1:0] secret; } exp_t;
    // Converter model: result due cycle and its Boolean shares.
    typedef struct { int due; logic [MASKWIDTH-1:0] z; } conv_t;
    exp_t  exp_q[$];
    conv_t conv_q[$];

    int cyc = 0, n_checks = 0, n_pass = 0;
    int m_state, m_ptr, m_inflight, m_fifo, m_mute;
    bit m_err, m_dvld, m_ena;
    logic [MASKWIDTH-1:0] m_a;
    bit inj_spur = 0, chk_en = 0;
    bit obs_issue, obs_pop, obs_rsp, obs_dvld;

    function automatic logic [K_WIDTH-1:0] share_sum(logic [MASKWIDTH-1:0] w);
        logic [K_WIDTH-1:0] s = '0;
        for (int i = 0; i < N_SHARES; i++) s += w[i*K_WIDTH +: K_WIDTH];
        return s;
    endfunction

    function automatic logic [K_WIDTH-1:0] share_xor(logic [MASKWIDTH-1:0] w);
        logic [K_WIDTH-1:0] s = '0;
        for (int i = 0; i < N_SHARES; i++) s ^= w[i*K_WIDTH +: K_WIDTH];
        return s;
    endfunction

    // Boolean re-masking of the arithmetic secret carried by w.
    function automatic logic [MASKWIDTH-1:0] bool_mask(logic [MASKWIDTH-1:0] w);
        logic [MASKWIDTH-1:0] z;
        logic [K_WIDTH-1:0]   acc = share_sum(w);
        for (int i = 0; i < N_SHARES - 1; i++) begin
            z[i*K_WIDTH +: K_WIDTH] = $urandom();
            acc ^= z[i*K_WIDTH +: K_WIDTH];
        end
        z[(N_SHARES-1)*K_WIDTH +: K_WIDTH] = acc;
        return z;
    endfunction

    function automatic logic [N_REQ*MASKWIDTH-1:0] rand_reqs();
        logic [N_REQ*MASKWIDTH-1:0] d;
        for (int i = 0; i < N_REQ * N_SHARES; i++) d[i*K_WIDTH +: K_WIDTH] = $urandom();
        return d;
    endfunction

    task automatic chk(input string tag, input logic [MASKWIDTH-1:0] obs,
                       input logic [MASKWIDTH-1:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = S_RUN; m_ptr = 0; m_inflight = 0; m_fifo = 0;
        m_mute = A2B_LAT; m_err = 0; m_dvld = 0; m_ena = 0; m_a = '0;
        exp_q.delete(); conv_q.delete();
    endtask

    // One clock cycle: inputs are already set by the caller at the falling edge.
    task automatic cycle();
        bit due, issue, pop, drained;
        int g, nxt;
        logic [N_REQ-1:0]     exp_rdy;
        logic [MASKWIDTH-1:0] gdata;
        due = (conv_q.size() > 0) && (conv_q[0].due == cyc);
        a2b_ovld = due || inj_spur;
        a2b_z = due ? conv_q[0].z : {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        g = -1; exp_rdy = '0; gdata = '0;
        if (!rst && m_state == S_RUN && rnd_vld && (OUT_DEPTH - m_inflight - m_fifo) > 0) begin
            for (int k = 0; k < N_REQ; k++)
                if (g < 0 && req_vld[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
        end
        issue = (g >= 0);
        if (issue) begin
            exp_rdy[g] = 1'b1;
            gdata = req_data[g*MASKWIDTH +: MASKWIDTH];
        end
        pop = (m_fifo > 0) && rsp_rdy;
        obs_issue = |req_rdy; obs_pop = rsp_vld && rsp_rdy;
        obs_rsp = rsp_vld; obs_dvld = a2b_dvld;
        if (chk_en) begin
            chk("req_rdy", req_rdy, exp_rdy);
            chk("rnd_rdy", rnd_rdy, issue);
            chk("a2b_dvld", a2b_dvld, m_dvld);
            chk("a2b_a", a2b_a, m_a);
            chk("a2b_ena", a2b_ena, m_ena);
            chk("halt_ack", halt_ack, m_state == S_HALT);
            chk("err", err, m_err);
            chk("rsp_vld", rsp_vld, m_fifo > 0);
            if (m_fifo > 0 && exp_q.size() > 0) begin
                chk("rsp_id", rsp_id, exp_q[0].id);
                chk("rsp_secret", share_xor(rsp_data), exp_q[0].secret);
            end
`ifdef SEC_A2B_SCHED_ZEROIZE_EN
            if (m_fifo == 0) chk("rsp_data_idle", rsp_data, '0);
`endif
        end
        if (!rst && a2b_dvld === 1'b1)
            conv_q.push_back('{due: cyc + A2B_LAT, z: bool_mask(a2b_a)});
        if (rst) begin
            model_reset();
        end else begin
            if (m_mute == 0 && (a2b_ovld != due)) m_err = 1;
            if (m_mute > 0) m_mute--;
            drained = (m_inflight == 0) && (m_fifo == 0);
            nxt = m_state;
            if (m_state == S_RUN && halt_req) nxt = S_DRAIN;
            else if (m_state == S_DRAIN && !halt_req) nxt = S_RUN;
            else if (m_state == S_DRAIN && drained) nxt = S_HALT;
            else if (m_state == S_HALT && !halt_req) nxt = S_RUN;
            if (issue) begin
                exp_q.push_back('{id: g, secret: share_sum(gdata)});
                m_ptr = (g + 1) % N_REQ;
                m_inflight++;
            end
            if (pop) begin
                void'(exp_q.pop_front());
                m_fifo--;
            end
            if (due) begin
                void'(conv_q.pop_front());
                m_inflight--;
                m_fifo++;
            end
            m_dvld = issue;
`ifdef SEC_A2B_SCHED_ZEROIZE_EN
            m_a = issue ? gdata : '0;
`else
            if (issue) m_a = gdata;
`endif
            m_ena = 1;
            m_state = nxt;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        req_vld = '0; rsp_rdy = 1'b1; rnd_vld = 1'b1;
        repeat (n) cycle();
    endtask

    initial begin
        int t1_dvld, t1_rsp, cnt, pop_at, iss_at;
        bit seen;
        rst = 1'b1; req_vld = '0; req_data = '0; rnd_vld = 1'b0; rsp_rdy = 1'b0;
        halt_req = 1'b0; a2b_ovld = 1'b0; a2b_z = '0;
        model_reset();
        @(negedge clk);
        cycle(); chk_en = 1; cycle(); cycle();
        rst = 1'b0;

        // T1: single request from requester 0, latency of issue and response.
        t1_dvld = -1; t1_rsp = -1;
        req_data = rand_reqs(); rnd_vld = 1'b1; rsp_rdy = 1'b1; req_vld = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            cycle();
            req_vld = '0;
            if (obs_dvld && t1_dvld < 0) t1_dvld = i;
            if (obs_rsp && t1_rsp < 0) t1_rsp = i;
        end
        chk("t1_dvld_cycle", t1_dvld, 1);
        chk("t1_rsp_cycle", t1_rsp, A2B_LAT + 2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req_vld = N_REQ'($urandom()); req_data = rand_reqs();
            rnd_vld = ($urandom_range(3) != 0); rsp_rdy = ($urandom_range(2) != 0);
            cycle();
        end

        // T2: all requesters, full rate.
        req_vld = '1; rnd_vld = 1'b1; rsp_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin req_data = rand_reqs(); cycle(); end

        // T3: back-pressure exhausts exactly OUT_DEPTH credits, then resume.
        idle(20);
        req_vld = '1; rsp_rdy = 1'b0; cnt = 0;
        for (int i = 0; i < 30; i++) begin req_data = rand_reqs(); cycle(); cnt += int'(obs_issue); end
        chk("t3_issue_cnt", cnt, OUT_DEPTH);
        rsp_rdy = 1'b1; pop_at = -1; iss_at = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (obs_pop && pop_at < 0) pop_at = i;
            if (obs_issue && pop_at >= 0 && iss_at < 0) iss_at = i;
        end
        chk("t3_resume_gap", iss_at - pop_at, 1);

        // T4: randomness toggling.
        for (int i = 0; i < 20; i++) begin rnd_vld = i[0] ? 1'b0 : 1'b1; cycle(); end

        // T5: halt with three words in flight, then release.
        idle(20);
        req_vld = '1; rnd_vld = 1'b1;
        repeat (3) cycle();
        req_vld = '1; halt_req = 1'b1; rnd_vld = 1'b1;
        req_vld = '0; cycle(); req_vld = '1;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin cycle(); seen = halt_ack; end
        chk("t5_halt_reached", seen, 1'b1);
        repeat (3) cycle();
        halt_req = 1'b0; cycle();
        cycle();
        chk("t5_grant_after_run", obs_issue, 1'b1);

        // Drain aborted by halt_req falling early.
        halt_req = 1'b1; repeat (3) cycle();
        halt_req = 1'b0; repeat (30) cycle();

        // Mid-operation reset, then spurious converter results: inside the
        // post-reset window (ignored) and at its first checked cycle (flagged).
        for (int i = 0; i < 20; i++) begin req_vld = N_REQ'($urandom()); req_data = rand_reqs(); cycle(); end
        rst = 1'b1; repeat (2) cycle();
        rst = 1'b0; req_vld = '0;
        for (int i = 0; i <= A2B_LAT + 5; i++) begin
            inj_spur = (i == 3) || (i == A2B_LAT);
            cycle();
            inj_spur = 1'b0;
            if (i == A2B_LAT - 1) chk("t6_err_muted", err, 1'b0);
        end
        chk("t6_err_sticky", err, 1'b1);
        chk("t6_fifo_empty", rsp_vld, 1'b0);

        // Traffic continues with err held.
        for (int i = 0; i < 60; i++) begin
            req_vld = N_REQ'($urandom()); req_data = rand_reqs(); rnd_vld = 1'b1; cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
